// File: rtl/ofm_axis_writer.sv
// OFM word FIFO feeding an AXI4-Stream master with per-tile tlast generation.
// The producer cannot be stalled, so any word that cannot be stored is dropped and flagged.
module ofm_axis_writer #(
    parameter int DATA_WIDTH     = 64,
    parameter int FIFO_DEPTH     = 512,
    parameter int ADDR_WIDTH     = 9,
    parameter int BEAT_CNT_WIDTH = 20
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [BEAT_CNT_WIDTH-1:0] total_beats,
    input  logic [DATA_WIDTH-1:0]     ofm_buffer_data,
    input  logic                      ofm_buffer_valid,
    output logic [DATA_WIDTH-1:0]     m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast,
    output logic [DATA_WIDTH/8-1:0]   m_axis_tkeep,
    output logic                      busy,
    output logic                      done,
    output logic                      overflow,
    output logic [ADDR_WIDTH:0]       fifo_level
);

    localparam int LVL_W = ADDR_WIDTH + 1;
    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [DATA_WIDTH-1:0]     mem_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]     wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]          level_q, level_d;
    logic                      out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]     out_data_q, out_data_d;
    logic [BEAT_CNT_WIDTH-1:0] total_q, total_d;
    logic [BEAT_CNT_WIDTH-1:0] in_cnt_q, in_cnt_d;
    logic [BEAT_CNT_WIDTH-1:0] out_cnt_q, out_cnt_d;
    logic                      overflow_q, overflow_d;
    logic                      zero_done_q, zero_done_d;

    logic hs, last_hs, load_out, fifo_empty, fifo_full;
    logic pop, wr_ok, bypass, push, drop, start_ok, start_zero;

    always_comb begin
        hs         = out_valid_q & m_axis_tready;
        last_hs    = hs & (out_cnt_q == total_q - BEAT_CNT_WIDTH'(1));
        load_out   = ~out_valid_q | hs;
        fifo_empty = (level_q == '0);
        fifo_full  = (level_q == FULL_LEVEL);
        pop        = load_out & ~fifo_empty;
        // A full FIFO still takes the word when the same cycle frees a slot.
        wr_ok      = (state_q == S_RUN) & ofm_buffer_valid & (in_cnt_q < total_q)
                   & ~(fifo_full & ~pop);
        bypass     = wr_ok & load_out & fifo_empty;
        push       = wr_ok & ~bypass;
        drop       = ofm_buffer_valid & ~wr_ok;
        start_ok   = (state_q == S_IDLE) & start & (total_beats != '0);
        start_zero = (state_q == S_IDLE) & start & (total_beats == '0);
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start_ok) state_d = S_RUN;
            S_RUN:   if (last_hs)  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = (state_q == S_RUN);
        done = (state_q == S_DONE) | zero_done_q;
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q + ADDR_WIDTH'(push);
        rd_ptr_d    = rd_ptr_q + ADDR_WIDTH'(pop);
        level_d     = level_q + LVL_W'(push) - LVL_W'(pop);
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (load_out) begin
            out_valid_d = ~fifo_empty | bypass;
            out_data_d  = fifo_empty ? ofm_buffer_data : mem_q[rd_ptr_q];
        end
        total_d     = start_ok ? total_beats : total_q;
        in_cnt_d    = start_ok ? '0 : in_cnt_q + BEAT_CNT_WIDTH'(wr_ok);
        out_cnt_d   = start_ok ? '0 : out_cnt_q + BEAT_CNT_WIDTH'(hs);
        overflow_d  = drop ? 1'b1 : (start_ok ? 1'b0 : overflow_q);
        zero_done_d = start_zero;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            total_q     <= '0;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            overflow_q  <= 1'b0;
            zero_done_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            total_q     <= total_d;
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            overflow_q  <= overflow_d;
            zero_done_q <= zero_done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= ofm_buffer_data;
    end

    always_comb begin
        m_axis_tvalid = out_valid_q;
        m_axis_tdata  = out_data_q;
        m_axis_tlast  = last_hs | (out_valid_q & (out_cnt_q == total_q - BEAT_CNT_WIDTH'(1)));
        m_axis_tkeep  = out_valid_q ? '1 : '0;
        overflow      = overflow_q;
        fifo_level    = level_q;
    end

endmodule

// File: doc/ofm_axis_writer.md
Name: ofm_axis_writer

Overview:
- Downstream stage of the convolution/maxpool post-processing unit.
- Consumes the 64-bit packed output-feature-map words (ofm_buffer_data / ofm_buffer_valid) and buffers them in a FIFO, because the producer has no backpressure.
- Emits them as an AXI4-Stream master toward the DMA (S2MM), asserting tlast on the final beat of each tile, whose length is programmed per tile.

Parameters:
DATA_WIDTH, 64, width of ofm words and m_axis_tdata
FIFO_DEPTH, 512, FIFO entries (power of two)
ADDR_WIDTH, 9, log2(FIFO_DEPTH)
BEAT_CNT_WIDTH, 20, width of the per-tile beat counters

Ports:
clk  in  1  system clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse, latches total_beats and begins a tile
total_beats  in  BEAT_CNT_WIDTH  beats expected in this tile
ofm_buffer_data  in  DATA_WIDTH  packed ofm word from the post-processing unit
ofm_buffer_valid  in  1  ofm_buffer_data valid this cycle (no ready; must be absorbed)
m_axis_tdata  out  DATA_WIDTH  stream data
m_axis_tvalid  out  1  stream valid
m_axis_tready  in  1  stream ready from DMA
m_axis_tlast  out  1  final beat of the tile
m_axis_tkeep  out  DATA_WIDTH/8  byte enables, all ones while tvalid, else 0
busy  out  1  high from accepted start until the tile completes
done  out  1  one-cycle pulse on tile completion
overflow  out  1  sticky error flag
fifo_level  out  ADDR_WIDTH+1  current FIFO occupancy, excluding the output register

Behaviour:
- Reset (async assert, sync release): state IDLE; FIFO pointers and level cleared; output register empty; all counters cleared; all outputs 0.
- FSM: IDLE, RUN, DONE.
  - IDLE + start with total_beats != 0: latch total_beats, clear in_cnt, out_cnt and overflow; go to RUN; busy=1 next cycle.
  - IDLE + start with total_beats == 0: done pulses the next cycle; stay IDLE; busy stays 0.
  - IDLE + ofm_buffer_valid: word dropped, overflow set.
  - RUN: start ignored.
  - RUN, last beat handshake (tvalid & tready & tlast): go to DONE.
  - DONE: done=1, busy=0 for exactly one cycle; unconditionally go to IDLE. start arriving in DONE is ignored.
- Write side, RUN only: word written when ofm_buffer_valid & in_cnt < total & not blocked.
  - Blocked = FIFO full and no same-cycle read from the FIFO. Full with a simultaneous pop: write accepted.
  - Blocked word is dropped and overflow set.
  - Words beyond total_beats are dropped and overflow set.
  - in_cnt increments only on an accepted write.
- Output register (first-word fall-through):
  - Loads from the FIFO when empty or when the current beat handshakes.
  - Empty FIFO with an empty output register: a write in cycle N gives m_axis_tvalid=1 in cycle N+1 (bypass). Latency is 1 cycle.
  - While tvalid & !tready, tdata, tlast and tkeep are held stable; tvalid never deasserts without a handshake.
- tlast = tvalid & (out_cnt == total-1). out_cnt increments on each handshake.
- Ordering: strict FIFO order; no reordering or duplication.
- fifo_level updates on the cycle after a push or pop; simultaneous push and pop leaves it unchanged.
- Reset asserted mid-tile: FIFO contents discarded, tvalid drops immediately (async), no done pulse.
- overflow clears only on reset or an accepted start.

Test Plan:
1. start total_beats=4; 4 consecutive ofm_buffer_valid words 0x11..0x44; tready=1 -> tvalid first seen 1 cycle after the first write; beats 0x11,0x22,0x33,0x44; tlast only on 0x44; done one cycle after; busy low; overflow=0.
2. total_beats=8; 8 writes with tready toggling 1,0,0,1 pattern -> no beat lost or duplicated; tdata/tlast stable across every stalled cycle; tkeep=0xFF whenever tvalid.
3. total_beats=600, tready=0 for 600 cycles of writes -> fifo_level reaches 512 (plus 1 in the output register); remaining 87 words dropped; overflow=1. Then tready=1 -> 513 beats out, the first 513 written. No tlast and no done (out_cnt never reaches 599).
4. FIFO full with tready=1 and a write in the same cycle -> write accepted; overflow stays 0; fifo_level unchanged.
5. start total_beats=0 -> done pulses the next cycle; busy stays 0; no tvalid. Then a stray ofm_buffer_valid in IDLE -> overflow=1, no stream output.
6. rst_n pulled low after 3 of 10 beats delivered -> tvalid, busy and fifo_level drop to 0 immediately. After release, a new start with total_beats=2 -> clean 2-beat tile with tlast on beat 2; overflow=0.
